// File: rtl/fifo_read_arbiter.sv
// Arbitrates the sample FIFO read port between the UART and I2S sinks.
// Optional starvation counter enabled by defining ARB_STARVE_CNT_EN.
module fifo_read_arbiter #(
  parameter int BPS    = 24,
  parameter int RD_LAT = 2
) (
  input  logic           in_clk,
  input  logic           in_rst_n,
  input  logic [1:0]     in_mode,
  input  logic           in_fifo_empty,
  input  logic [BPS-1:0] in_sample,
  input  logic           in_uart_req,
  input  logic           in_i2s_req,
  output logic           out_fifo_en,
  output logic [BPS-1:0] out_sample,
  output logic           out_uart_valid,
  output logic           out_i2s_valid,
  output logic           out_busy
`ifdef ARB_STARVE_CNT_EN
  ,
  output logic [15:0]    out_starve_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_DELIVER
  } state_t;

  state_t     state;
  logic [1:0] wait_cnt;
  logic       grant_uart;
  logic       last_uart;
  logic       elig_uart;
  logic       elig_i2s;
  logic       pick_uart;

  always_comb begin
    elig_uart = in_uart_req & in_mode[0];
    elig_i2s  = in_i2s_req  & in_mode[1];
    // On a tie the sink that was not served last takes the grant.
    pick_uart = elig_uart & (~elig_i2s | ~last_uart);
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      grant_uart     <= 1'b0;
      last_uart      <= 1'b0;
      out_fifo_en    <= 1'b0;
      out_sample     <= '0;
      out_uart_valid <= 1'b0;
      out_i2s_valid  <= 1'b0;
      out_busy       <= 1'b0;
    end else begin
      out_fifo_en    <= 1'b0;
      out_uart_valid <= 1'b0;
      out_i2s_valid  <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((elig_uart | elig_i2s) && !in_fifo_empty) begin
            state       <= S_READ;
            grant_uart  <= pick_uart;
            out_fifo_en <= 1'b1;
            out_busy    <= 1'b1;
          end
        end
        S_READ: begin
          state    <= S_WAIT;
          wait_cnt <= 2'(RD_LAT - 1);
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state          <= S_DELIVER;
            out_sample     <= in_sample;
            last_uart      <= grant_uart;
            out_uart_valid <= grant_uart;
            out_i2s_valid  <= ~grant_uart;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_DELIVER: begin
          state    <= S_IDLE;
          out_busy <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STARVE_CNT_EN
  always_ff @(posedge in_clk) begin
    if (!in_rst_n || in_mode == 2'b00) begin
      out_starve_cnt <= '0;
    end else if (state == S_IDLE && (elig_uart | elig_i2s) && in_fifo_empty &&
                 out_starve_cnt != '1) begin
      out_starve_cnt <= out_starve_cnt + 16'd1;
    end
  end
`endif

endmodule
